// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32 x 32 RISC-V integer register file, 2 async read ports, 1 sync write port
//
// Purpose:
//   Integer register file x0..x31 for the core datapath. x0 is not stored and
//   always reads zero; writes addressed to it are discarded.
//
// Ports:
//   clk      in   1           clock, all state updates on rising edge
//   rst      in   1           synchronous active-high reset, clears x1..x31
//   we       in   1           write enable, port 3
//   readA1   in   ADDR_WIDTH  read address, port 1
//   readA2   in   ADDR_WIDTH  read address, port 2
//   writeA3  in   ADDR_WIDTH  write address, port 3
//   data     in   DATA_WIDTH  write data, port 3
//   RD1      out  DATA_WIDTH  read data, port 1 (combinational)
//   RD2      out  DATA_WIDTH  read data, port 2 (combinational)
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] readA1,
    input  logic [ADDR_WIDTH-1:0] readA2,
    input  logic [ADDR_WIDTH-1:0] writeA3,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Entry 0 is never written, so it carries no state; the read muxes
    // force it to zero regardless of what the array holds there.
    logic [DATA_WIDTH-1:0] r_regs [0:DEPTH-1];

    logic w_wr_en;
    assign w_wr_en = we && (writeA3 != '0);

    // Reset takes priority over a write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[writeA3] <= data;
        end
    end

    // No write-to-read bypass: a same-cycle write is visible only after the
    // edge. Forwarding is the pipeline's job.
    assign RD1 = (readA1 == '0) ? '0 : r_regs[readA1];
    assign RD2 = (readA2 == '0) ? '0 : r_regs[readA2];

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  readA1;
    logic [4:0]  readA2;
    logic [4:0]  writeA3;
    logic [31:0] data;
    logic [31:0] RD1;
    logic [31:0] RD2;

    int checks;
    int errors;

    reg_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .readA1  (readA1),
        .readA2  (readA2),
        .writeA3 (writeA3),
        .data    (data),
        .RD1     (RD1),
        .RD2     (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        we      = 1'b0;
        readA1  = 5'd0;
        readA2  = 5'd0;
        writeA3 = 5'd0;
        data    = 32'h0;
        #2;

        // Reset then read
        rst = 1'b1;
        tick();
        rst = 1'b0;
        readA1 = 5'd0; readA2 = 5'd0; #1;
        check("reset_rd1_x0", RD1, 32'h0000_0000);
        check("reset_rd2_x0", RD2, 32'h0000_0000);
        readA1 = 5'd31; readA2 = 5'd17; #1;
        check("reset_rd1_x31", RD1, 32'h0000_0000);
        check("reset_rd2_x17", RD2, 32'h0000_0000);

        // Write/read x1 on port 1
        we = 1'b1; writeA3 = 5'd1; data = 32'hEEAD_B00C;
        tick();
        we = 1'b0;
        readA1 = 5'd1; #1;
        check("wr_x1_rd1", RD1, 32'hEEAD_B00C);

        // Write/read x2 on port 2, x1 unchanged
        we = 1'b1; writeA3 = 5'd2; data = 32'h56AB_9900;
        tick();
        we = 1'b0;
        readA2 = 5'd2; #1;
        check("wr_x2_rd2", RD2, 32'h56AB_9900);
        check("x1_kept_rd1", RD1, 32'hEEAD_B00C);

        // x0 hardwired to zero
        we = 1'b1; writeA3 = 5'd0; data = 32'hFFFF_FFFF;
        tick();
        we = 1'b0;
        readA1 = 5'd0; readA2 = 5'd0; #1;
        check("x0_rd1", RD1, 32'h0000_0000);
        check("x0_rd2", RD2, 32'h0000_0000);

        // Write gating with we=0
        we = 1'b0; writeA3 = 5'd1; data = 32'h1234_5678;
        tick();
        readA1 = 5'd1; #1;
        check("we0_x1_kept", RD1, 32'hEEAD_B00C);

        // Reset wins over simultaneous write
        rst = 1'b1; we = 1'b1; writeA3 = 5'd3; data = 32'hA5A5_A5A5;
        tick();
        rst = 1'b0; we = 1'b0;
        readA1 = 5'd1; readA2 = 5'd3; #1;
        check("rst_x1_clear", RD1, 32'h0000_0000);
        check("rst_x3_dropped", RD2, 32'h0000_0000);
        readA2 = 5'd2; #1;
        check("rst_x2_clear", RD2, 32'h0000_0000);

        // Read-during-write to x5, with a non-zero old value
        we = 1'b1; writeA3 = 5'd5; data = 32'h1111_2222;
        tick();
        readA1 = 5'd5; we = 1'b1; writeA3 = 5'd5; data = 32'hCAFE_F00D; #1;
        check("rdw_before_edge", RD1, 32'h1111_2222);
        tick();
        we = 1'b0;
        readA2 = 5'd5; #1;
        check("rdw_after_rd1", RD1, 32'hCAFE_F00D);
        check("rdw_after_rd2", RD2, 32'hCAFE_F00D);

        // Top entry, both ports on the same register
        we = 1'b1; writeA3 = 5'd31; data = 32'h8000_0001;
        tick();
        we = 1'b0;
        readA1 = 5'd31; readA2 = 5'd31; #1;
        check("x31_rd1", RD1, 32'h8000_0001);
        check("x31_rd2", RD2, 32'h8000_0001);
        readA1 = 5'd30; #1;
        check("x30_untouched", RD1, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
